// File: rtl/vx_warp_ctl.sv
// Warp control-transfer producer: turns resolved jal/branch/tmc/wspawn commands into per-warp strobes.
// Optional VX_WARP_CTL_PERF_EN adds jal / taken-branch / spawn event counters.
module vx_warp_ctl #(
    parameter int NT      = 4,
    parameter int NW      = 8,
    parameter int NW_BITS = $clog2(NW)
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NW_BITS-1:0] in_warp_num,
    input  logic               in_is_jal,
    input  logic [31:0]        in_jal_dest,
    input  logic               in_is_branch,
    input  logic               in_branch_taken,
    input  logic [31:0]        in_branch_dest,
    input  logic               in_is_tmc,
    input  logic [NT-1:0]      in_tmc_mask,
    input  logic               in_is_wspawn,
    input  logic [NW_BITS:0]   in_wspawn_count,
    input  logic [31:0]        in_wspawn_pc,

    output logic [NW-1:0]      out_jal,
    output logic [31:0]        out_jal_dest,
    output logic [NW-1:0]      out_branch_dir,
    output logic [31:0]        out_branch_dest,
    output logic [NW-1:0]      out_change_mask,
    output logic [NT-1:0]      out_thread_mask,
    output logic [NW-1:0]      out_wspawn,
    output logic [31:0]        out_wspawn_pc,
    output logic [NW-1:0]      out_warp_done,
    output logic               out_flush,
    output logic               out_busy,

    output logic [31:0]        perf_jal_count,
    output logic [31:0]        perf_branch_taken_count,
    output logic [31:0]        perf_spawn_count
);

    // state | meaning
    // IDLE  | accepting commands
    // SPAWN | pulsing out_wspawn for warps 1..count-1, commands stalled
    typedef enum logic {IDLE, SPAWN} state_t;

    localparam logic [NW_BITS:0] MAX_COUNT = (NW_BITS+1)'(NW);
    localparam logic [NW_BITS:0] MIN_SPAWN = (NW_BITS+1)'(2);

    state_t             state;
    logic [NW_BITS-1:0] spawn_idx;
    logic [NW_BITS-1:0] spawn_last;
    logic [NW_BITS-1:0] spawn_next;
    logic               accept;
    logic [NW-1:0]      warp_sel;
    logic [NW_BITS:0]   count_clamp;

    assign in_ready    = (state == IDLE);
    assign out_busy    = (state == SPAWN);
    assign accept      = in_valid & in_ready;
    assign warp_sel    = NW'(1) << in_warp_num;
    assign count_clamp = (in_wspawn_count > MAX_COUNT) ? MAX_COUNT : in_wspawn_count;
    assign spawn_next  = spawn_idx + NW_BITS'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            spawn_idx       <= '0;
            spawn_last      <= '0;
            out_jal         <= '0;
            out_jal_dest    <= '0;
            out_branch_dir  <= '0;
            out_branch_dest <= '0;
            out_change_mask <= '0;
            out_thread_mask <= '0;
            out_wspawn      <= '0;
            out_wspawn_pc   <= '0;
            out_warp_done   <= '0;
            out_flush       <= 1'b0;
        end else begin
            out_jal         <= '0;
            out_branch_dir  <= '0;
            out_change_mask <= '0;
            out_warp_done   <= '0;
            out_wspawn      <= '0;
            out_flush       <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_is_jal) begin
                            out_jal      <= warp_sel;
                            out_jal_dest <= in_jal_dest;
                            out_flush    <= 1'b1;
                        end else if (in_is_branch && in_branch_taken) begin
                            out_branch_dir <= warp_sel;
                            out_flush      <= 1'b1;
                        end
                        if (in_is_branch) begin
                            out_branch_dest <= in_branch_dest;
                        end
                        if (in_is_tmc) begin
                            out_change_mask <= warp_sel;
                            out_thread_mask <= in_tmc_mask;
                            if (in_tmc_mask == '0) begin
                                out_warp_done <= warp_sel;
                            end
                        end
                        if (in_is_wspawn) begin
                            out_wspawn_pc <= in_wspawn_pc;
                            // Warp 1 pulses straight off the accept edge; warp 0 is never spawned.
                            if (count_clamp >= MIN_SPAWN) begin
                                out_wspawn <= NW'(2);
                                spawn_idx  <= NW_BITS'(1);
                                spawn_last <= count_clamp[NW_BITS-1:0] - NW_BITS'(1);
                                state      <= SPAWN;
                            end
                        end
                    end
                end
                SPAWN: begin
                    if (spawn_idx == spawn_last) begin
                        spawn_idx <= '0;
                        state     <= IDLE;
                    end else begin
                        spawn_idx  <= spawn_next;
                        out_wspawn <= NW'(1) << spawn_next;
                    end
                end
                default: begin
                    state     <= IDLE;
                    spawn_idx <= '0;
                end
            endcase
        end
    end

`ifdef VX_WARP_CTL_PERF_EN
    // Counters see the registered strobes, so each event lands one cycle after its pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_jal_count          <= '0;
            perf_branch_taken_count <= '0;
            perf_spawn_count        <= '0;
        end else begin
            if (|out_jal)        perf_jal_count          <= perf_jal_count + 32'd1;
            if (|out_branch_dir) perf_branch_taken_count <= perf_branch_taken_count + 32'd1;
            if (|out_wspawn)     perf_spawn_count        <= perf_spawn_count + 32'd1;
        end
    end
`else
    assign perf_jal_count          = '0;
    assign perf_branch_taken_count = '0;
    assign perf_spawn_count        = '0;
`endif

endmodule

// File: tb/tb_vx_warp_ctl.sv
// Scoreboard bench for vx_warp_ctl: a command-level model pushes one expected output frame per
// clock; a negedge monitor pops and compares against the DUT.
module tb_vx_warp_ctl;
    localparam int NT  = 4;
    localparam int NW  = 8;
    localparam int NWB = 3;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [NWB-1:0] in_warp_num;
    logic           in_is_jal;
    logic [31:0]    in_jal_dest;
    logic           in_is_branch;
    logic           in_branch_taken;
    logic [31:0]    in_branch_dest;
    logic           in_is_tmc;
    logic [NT-1:0]  in_tmc_mask;
    logic           in_is_wspawn;
    logic [NWB:0]   in_wspawn_count;
    logic [31:0]    in_wspawn_pc;
    logic [NW-1:0]  out_jal, out_branch_dir, out_change_mask, out_wspawn, out_warp_done;
    logic [31:0]    out_jal_dest, out_branch_dest, out_wspawn_pc;
    logic [NT-1:0]  out_thread_mask;
    logic           out_flush, out_busy;
    logic [31:0]    perf_jal_count, perf_branch_taken_count, perf_spawn_count;

    vx_warp_ctl #(.NT(NT), .NW(NW), .NW_BITS(NWB)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_warp_num(in_warp_num),
        .in_is_jal(in_is_jal), .in_jal_dest(in_jal_dest),
        .in_is_branch(in_is_branch), .in_branch_taken(in_branch_taken), .in_branch_dest(in_branch_dest),
        .in_is_tmc(in_is_tmc), .in_tmc_mask(in_tmc_mask),
        .in_is_wspawn(in_is_wspawn), .in_wspawn_count(in_wspawn_count), .in_wspawn_pc(in_wspawn_pc),
        .out_jal(out_jal), .out_jal_dest(out_jal_dest),
        .out_branch_dir(out_branch_dir), .out_branch_dest(out_branch_dest),
        .out_change_mask(out_change_mask), .out_thread_mask(out_thread_mask),
        .out_wspawn(out_wspawn), .out_wspawn_pc(out_wspawn_pc),
        .out_warp_done(out_warp_done), .out_flush(out_flush), .out_busy(out_busy),
        .perf_jal_count(perf_jal_count), .perf_branch_taken_count(perf_branch_taken_count),
        .perf_spawn_count(perf_spawn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] jal, br, cm, wd, ws;
        logic          flush, busy, ready;
        logic [31:0]   jd, bd, wpc, pj, pb, ps;
        logic [NT-1:0] tm;
    } frame_t;

    frame_t sb[$];
    frame_t cur;
    int     spawn_q[$];
    bit     model_ready;
    int     n_chk  = 0;
    int     n_fail = 0;

    function automatic frame_t zero_frame();
        frame_t f;
        f.jal = '0; f.br = '0; f.cm = '0; f.wd = '0; f.ws = '0;
        f.flush = 1'b0; f.busy = 1'b0; f.ready = 1'b1;
        f.jd = '0; f.bd = '0; f.wpc = '0; f.pj = '0; f.pb = '0; f.ps = '0;
        f.tm = '0;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            frame_t f;
            f = sb.pop_front();
            chk("out_jal", 32'(out_jal), 32'(f.jal));
            chk("out_branch_dir", 32'(out_branch_dir), 32'(f.br));
            chk("out_change_mask", 32'(out_change_mask), 32'(f.cm));
            chk("out_warp_done", 32'(out_warp_done), 32'(f.wd));
            chk("out_wspawn", 32'(out_wspawn), 32'(f.ws));
            chk("out_flush", 32'(out_flush), 32'(f.flush));
            chk("out_busy", 32'(out_busy), 32'(f.busy));
            chk("in_ready", 32'(in_ready), 32'(f.ready));
            chk("out_jal_dest", out_jal_dest, f.jd);
            chk("out_branch_dest", out_branch_dest, f.bd);
            chk("out_wspawn_pc", out_wspawn_pc, f.wpc);
            chk("out_thread_mask", 32'(out_thread_mask), 32'(f.tm));
`ifdef VX_WARP_CTL_PERF_EN
            chk("perf_jal", perf_jal_count, f.pj);
            chk("perf_branch", perf_branch_taken_count, f.pb);
            chk("perf_spawn", perf_spawn_count, f.ps);
`else
            chk("perf_jal", perf_jal_count, 32'd0);
            chk("perf_branch", perf_branch_taken_count, 32'd0);
            chk("perf_spawn", perf_spawn_count, 32'd0);
`endif
        end
    end

    // Predict the outputs produced by the coming clock edge, push them, then advance one cycle.
    task automatic step();
        frame_t f;
        int idx;
        int c;
        logic [NW-1:0] sel;
        idx = -1;
        f = cur;
        f.jal = '0; f.br = '0; f.cm = '0; f.wd = '0; f.ws = '0; f.flush = 1'b0;
        if (reset) begin
            f = zero_frame();
            spawn_q.delete();
        end else begin
            f.pj = cur.pj + ((|cur.jal) ? 32'd1 : 32'd0);
            f.pb = cur.pb + ((|cur.br) ? 32'd1 : 32'd0);
            f.ps = cur.ps + ((|cur.ws) ? 32'd1 : 32'd0);
            sel = NW'(1) << in_warp_num;
            if (spawn_q.size() > 0) begin
                idx = spawn_q.pop_front();
            end else if (in_valid && model_ready) begin
                if (in_is_jal) begin
                    f.jal = sel; f.jd = in_jal_dest; f.flush = 1'b1;
                end else if (in_is_branch && in_branch_taken) begin
                    f.br = sel; f.flush = 1'b1;
                end
                if (in_is_branch) f.bd = in_branch_dest;
                if (in_is_tmc) begin
                    f.cm = sel; f.tm = in_tmc_mask;
                    if (in_tmc_mask == '0) f.wd = sel;
                end
                if (in_is_wspawn) begin
                    f.wpc = in_wspawn_pc;
                    c = (int'(in_wspawn_count) > NW) ? NW : int'(in_wspawn_count);
                    for (int i = 1; i < c; i++) spawn_q.push_back(i);
                    if (spawn_q.size() > 0) idx = spawn_q.pop_front();
                end
            end
            if (idx >= 0) f.ws = NW'(1) << idx;
            f.busy  = (idx >= 0);
            f.ready = !f.busy;
        end
        model_ready = f.ready;
        cur = f;
        sb.push_back(f);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmd();
        in_valid = 1'b0; in_warp_num = '0;
        in_is_jal = 1'b0; in_jal_dest = '0;
        in_is_branch = 1'b0; in_branch_taken = 1'b0; in_branch_dest = '0;
        in_is_tmc = 1'b0; in_tmc_mask = '0;
        in_is_wspawn = 1'b0; in_wspawn_count = '0; in_wspawn_pc = '0;
    endtask

    // Present the staged command, holding it while the DUT is expected to stall.
    task automatic send();
        int n;
        n = 0;
        in_valid = 1'b1;
        while (!model_ready && n < 64) begin
            step();
            n++;
        end
        if (!model_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: ready never returned after %0d cycles", n);
        end
        step();
        clear_cmd();
    endtask

    initial begin
        reset = 1'b1;
        clear_cmd();
        cur = zero_frame();
        model_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        in_warp_num = 3'd3; in_is_jal = 1'b1; in_jal_dest = 32'h8000_0100;
        send(); step();

        in_warp_num = 3'd2; in_is_branch = 1'b1; in_branch_taken = 1'b0; in_branch_dest = 32'h0000_0300;
        send(); step();
        in_warp_num = 3'd2; in_is_branch = 1'b1; in_branch_taken = 1'b1; in_branch_dest = 32'h0000_0200;
        send(); step();

        in_warp_num = 3'd1; in_is_jal = 1'b1; in_jal_dest = 32'h0000_4444;
        in_is_branch = 1'b1; in_branch_taken = 1'b1; in_branch_dest = 32'h0000_5555;
        send();

        in_warp_num = 3'd5; in_is_tmc = 1'b1; in_tmc_mask = 4'b0000;
        send();
        in_warp_num = 3'd6; in_is_tmc = 1'b1; in_tmc_mask = 4'b1010;
        in_is_jal = 1'b1; in_jal_dest = 32'h0000_0abc;
        send();

        in_warp_num = 3'd0; in_is_wspawn = 1'b1; in_wspawn_count = 4'd4; in_wspawn_pc = 32'h0000_1000;
        send();
        in_warp_num = 3'd0; in_is_wspawn = 1'b1; in_wspawn_count = 4'd1; in_wspawn_pc = 32'h0000_2000;
        send();
        in_warp_num = 3'd0; in_is_wspawn = 1'b1; in_wspawn_count = 4'd15; in_wspawn_pc = 32'h0000_3000;
        send();
        in_warp_num = 3'd4; in_is_wspawn = 1'b1; in_wspawn_count = 4'd2; in_wspawn_pc = 32'h0000_3800;
        send();

        in_warp_num = 3'd5; in_is_wspawn = 1'b1; in_wspawn_count = 4'd8; in_wspawn_pc = 32'h0000_4000;
        send();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();

        for (int k = 0; k < 800; k++) begin
            if (model_ready) begin
                in_valid        = ($urandom_range(0, 3) != 0);
                in_warp_num     = NWB'($urandom_range(0, NW - 1));
                in_is_jal       = ($urandom_range(0, 3) == 0);
                in_jal_dest     = $urandom;
                in_is_branch    = ($urandom_range(0, 2) == 0);
                in_branch_taken = $urandom_range(0, 1) == 1;
                in_branch_dest  = $urandom;
                in_is_tmc       = ($urandom_range(0, 3) == 0);
                in_tmc_mask     = ($urandom_range(0, 2) == 0) ? '0 : NT'($urandom);
                in_is_wspawn    = ($urandom_range(0, 7) == 0);
                in_wspawn_count = (NWB+1)'($urandom_range(0, 15));
                in_wspawn_pc    = $urandom;
            end
            reset = ($urandom_range(0, 120) == 0);
            step();
        end
        reset = 1'b0;
        clear_cmd();
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
